display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_pkg.sv | 22 ++
 rtl/display_scan_ctrl_hex_to_seg7.sv | 11 +
 rtl/display_scan_ctrl.sv | 100 ++++++++++
 tb/tb_display_scan_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: shared constants, scan state type and hex segment encodings
package display_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
    localparam logic [6:0] SEG_ENC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment decode
module hex_to_seg7
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_ENC[i_hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 8-digit seven-segment scanner with per-slot blanking
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int TICK_COUNT   = 200000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SLOT_LAST = CW'(TICK_COUNT - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    scan_state_t     r_state;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [31:0]     r_digits;
    logic [7:0]      r_digit_en;
    logic [7:0]      r_dp;
    logic [7:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp_n;

    logic            w_tick;
    logic            w_frame_end;
    logic            w_show;
    logic [3:0]      w_nibble;
    logic [6:0]      w_seg;

    assign w_tick      = (r_state != ST_OFF) && (r_cnt == SLOT_LAST);
    assign w_frame_end = w_tick && (r_idx == IDX_LAST);
    assign w_show      = (r_state == ST_SHOW) && r_digit_en[r_idx];
    assign w_nibble    = r_digits[4*r_idx +: 4];

    hex_to_seg7 u_dec (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    // Scan FSM: slot timing, digit index, frame-start shadow capture and registered drive outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_digits   <= '0;
            r_digit_en <= '0;
            r_dp       <= '0;
            r_an       <= 8'hFF;
            r_seg      <= SEG_OFF;
            r_dp_n     <= 1'b1;
        end else begin
            r_an   <= w_show ? ~(8'd1 << r_idx) : 8'hFF;
            r_seg  <= w_show ? w_seg : SEG_OFF;
            r_dp_n <= w_show ? ~r_dp[r_idx] : 1'b1;
            if (!en) begin
                r_state <= ST_OFF;
                r_cnt   <= '0;
                r_idx   <= '0;
            end else if (r_state == ST_OFF) begin
                r_state    <= ST_BLANK;
                r_digits   <= digits;
                r_digit_en <= digit_en;
                r_dp       <= dp;
            end else if (w_tick) begin
                r_state <= ST_BLANK;
                r_cnt   <= '0;
                r_idx   <= r_idx + 1'b1;
                if (w_frame_end) begin
                    r_digits   <= digits;
                    r_digit_en <= digit_en;
                    r_dp       <= dp;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_state == ST_BLANK && r_cnt == BLANK_END)
                    r_state <= ST_SHOW;
            end
        end
    end

    // The frame pulse is gated by en so a disable on the final tick suppresses it
    assign frame_done = en && w_frame_end;
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp_n       = r_dp_n;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized self-checking bench against a slot-arithmetic reference model
module tb_display_scan_ctrl;

    localparam int T = 10;
    localparam int B = 2;
    localparam int FRAME = 8 * T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] digits = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    // Reference model: cycles since frame start, plus frame snapshot of inputs
    bit          m_run = 0;
    int          m_k = 0;
    logic [31:0] m_dig = '0;
    logic [7:0]  m_msk = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  exp_an = 8'hFF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dpn = 1'b1;
    logic        exp_fd = 1'b0;

    display_scan_ctrl #(.TICK_COUNT(T), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp         (dp),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        case (h)
            4'h0: ref_seg = 7'h40; 4'h1: ref_seg = 7'h79; 4'h2: ref_seg = 7'h24; 4'h3: ref_seg = 7'h30;
            4'h4: ref_seg = 7'h19; 4'h5: ref_seg = 7'h12; 4'h6: ref_seg = 7'h02; 4'h7: ref_seg = 7'h78;
            4'h8: ref_seg = 7'h00; 4'h9: ref_seg = 7'h10; 4'hA: ref_seg = 7'h08; 4'hB: ref_seg = 7'h03;
            4'hC: ref_seg = 7'h46; 4'hD: ref_seg = 7'h21; 4'hE: ref_seg = 7'h06; default: ref_seg = 7'h0E;
        endcase
    endfunction

    // One clock: visible outputs follow the pre-edge slot position, then the model advances
    task automatic cyc();
        int d;
        int ph;
        bit show;
        ph = m_k % T;
        d = (m_k / T) % 8;
        show = m_run && ph >= B && m_msk[d];
        exp_an = show ? ~(8'd1 << d) : 8'hFF;
        exp_seg = show ? ref_seg(m_dig[4*d +: 4]) : 7'h7F;
        exp_dpn = show ? ~m_dp[d] : 1'b1;
        @(posedge clk);
        if (!en) begin
            m_run = 0;
            m_k = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_k = 0;
            m_dig = digits; m_msk = digit_en; m_dp = dp;
        end else begin
            m_k = (m_k + 1) % FRAME;
            if (m_k == 0) begin
                m_dig = digits; m_msk = digit_en; m_dp = dp;
            end
        end
        @(negedge clk);
        exp_fd = m_run && en && (m_k == FRAME - 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        digits = 32'h76543210;
        digit_en = 8'hFF;
        dp = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (an !== 8'hFF) begin failures++; $display("FAIL reset_an got=%h exp=ff", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        checks++; if (dp_n !== 1'b1) begin failures++; $display("FAIL reset_dpn got=%b exp=1", dp_n); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        m_run = 0;
        m_k = 0;
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int pulses = 0;
        for (int c = 0; c < 2 * FRAME + 4; c++) begin
            cyc();
            pulses += frame_done ? 1 : 0;
            checks++;
            if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dpn, exp_fd}) begin
                failures++;
                $display("FAIL scan c=%0d an=%h/%h seg=%h/%h dpn=%b/%b fd=%b/%b", c, an, exp_an, seg, exp_seg, dp_n, exp_dpn, frame_done, exp_fd);
            end
        end
        checks++; if (pulses !== 2) begin failures++; $display("FAIL scan_pulses got=%0d exp=2", pulses); end
    endtask

    task automatic test_mask();
        digit_en = 8'hFB;
        digits = $urandom;
        dp = 8'($urandom);
        for (int c = 0; c < 2 * FRAME; c++) begin
            cyc();
            checks++;
            if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dpn, exp_fd}) begin
                failures++;
                $display("FAIL mask c=%0d an=%h/%h seg=%h/%h dpn=%b/%b fd=%b/%b", c, an, exp_an, seg, exp_seg, dp_n, exp_dpn, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_shadow();
        int guard = 0;
        digit_en = 8'hFF;
        while (!(m_run && m_k == 3 * T + B) && guard < 2 * FRAME) begin
            cyc();
            guard++;
        end
        checks++; if (guard >= 2 * FRAME) begin failures++; $display("FAIL shadow_sync got=timeout exp=digit3"); end
        digits = 32'hFFFFFFFF;
        for (int c = 0; c < FRAME; c++) begin
            cyc();
            checks++;
            if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dpn, exp_fd}) begin
                failures++;
                $display("FAIL shadow c=%0d an=%h/%h seg=%h/%h dpn=%b/%b fd=%b/%b", c, an, exp_an, seg, exp_seg, dp_n, exp_dpn, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_abort();
        int guard = 0;
        while (!(m_run && m_k == FRAME - 1) && guard < 2 * FRAME) begin
            cyc();
            guard++;
        end
        checks++; if (guard >= 2 * FRAME) begin failures++; $display("FAIL abort_sync got=timeout exp=digit7_tick"); end
        en = 1'b0;
        #1;
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL abort_fd got=%b exp=0", frame_done); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dpn, exp_fd}) begin
                failures++;
                $display("FAIL abort c=%0d an=%h/%h seg=%h/%h dpn=%b/%b fd=%b/%b", c, an, exp_an, seg, exp_seg, dp_n, exp_dpn, frame_done, exp_fd);
            end
        end
        en = 1'b1;
        digits = 32'h0123ABCD;
        for (int c = 0; c < 3 * T; c++) begin
            cyc();
            checks++;
            if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dpn, exp_fd}) begin
                failures++;
                $display("FAIL restart c=%0d an=%h/%h seg=%h/%h dpn=%b/%b fd=%b/%b", c, an, exp_an, seg, exp_seg, dp_n, exp_dpn, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_async_rst();
        int guard = 0;
        while (!(m_run && (m_k % T) == B + 2) && guard < 2 * FRAME) begin
            cyc();
            guard++;
        end
        checks++; if (guard >= 2 * FRAME || an === 8'hFF) begin failures++; $display("FAIL arst_pre got=%h exp=one_low", an); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, dp_n, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL arst an=%h/ff seg=%h/7f dpn=%b/1 fd=%b/0", an, seg, dp_n, frame_done);
        end
        m_run = 0;
        m_k = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2 * T; c++) begin
            cyc();
            checks++;
            if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dpn, exp_fd}) begin
                failures++;
                $display("FAIL post_arst c=%0d an=%h/%h seg=%h/%h dpn=%b/%b fd=%b/%b", c, an, exp_an, seg, exp_seg, dp_n, exp_dpn, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 6 * FRAME; c++) begin
            if ($urandom_range(0, 7) == 0) digits = $urandom;
            if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 15) == 0) dp = 8'($urandom);
            if ($urandom_range(0, 99) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            cyc();
            checks++;
            if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dpn, exp_fd}) begin
                failures++;
                $display("FAIL random c=%0d an=%h/%h seg=%h/%h dpn=%b/%b fd=%b/%b", c, an, exp_an, seg, exp_seg, dp_n, exp_dpn, frame_done, exp_fd);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan();
        test_mask();
        test_shadow();
        test_abort();
        test_async_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
